// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART byte transmitter/receiver pair.
//   rx_state_t  - receiver FSM states
//   BAUD_*      - 3-bit baud_set codes (shared with the transmitter)
//   DIV_*       - clk cycles per 16x oversampling tick, minus 1, at 50 MHz
//   START_BIT / STOP_BIT - line levels of the framing bits
//   baud_div()  - maps a baud_set code to its tick divisor (unknown codes -> 9600)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [2:0] BAUD_9600   = 3'b000;
    localparam logic [2:0] BAUD_19200  = 3'b001;
    localparam logic [2:0] BAUD_38400  = 3'b010;
    localparam logic [2:0] BAUD_57600  = 3'b011;
    localparam logic [2:0] BAUD_115200 = 3'b100;

    localparam logic [15:0] DIV_9600   = 16'd324;
    localparam logic [15:0] DIV_19200  = 16'd162;
    localparam logic [15:0] DIV_38400  = 16'd80;
    localparam logic [15:0] DIV_57600  = 16'd53;
    localparam logic [15:0] DIV_115200 = 16'd26;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic [15:0] baud_div(input logic [2:0] code);
        case (code)
            BAUD_9600:   return DIV_9600;
            BAUD_19200:  return DIV_19200;
            BAUD_38400:  return DIV_38400;
            BAUD_57600:  return DIV_57600;
            BAUD_115200: return DIV_115200;
            default:     return DIV_9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: programmable tick generator (one-cycle pulse every div+1 clocks).
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   div  - cycles per tick minus 1
//   en   - counter runs only while high
//   clr  - synchronous clear; restarts the tick phase from 0
//   tick - one-cycle pulse when the counter reaches div
module uart_baud_tick #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] div,
    input  logic         en,
    input  logic         clr,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    assign tick = en && !clr && (cnt_q == div);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, 16x oversampling, 2-of-3 majority vote at mid-bit.
//   clk        - system clock (50 MHz)
//   rst        - asynchronous active-low reset
//   baud_set   - rate select (000=9600 .. 100=115200, others=9600), latched while idle
//   rs232_Rx   - serial line, idle high, asynchronous to clk
//   data_byte  - last received byte (LSB first on the line)
//   rx_done    - one-cycle pulse when data_byte updates
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   parity_err - one-cycle pulse on bad even parity; tied 0 unless enabled
//   uart_state - high from start edge until the frame decision (and while in break)
// Build option: define UART_RX_PARITY_EN to expect an even parity bit after bit 7.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_set,
    input  logic       rs232_Rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       uart_state
);

    localparam int unsigned CNT_W = $clog2(OVS);
    localparam logic [CNT_W-1:0] TICK_S0   = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_S1   = CNT_W'(OVS / 2);
    localparam logic [CNT_W-1:0] TICK_DEC  = CNT_W'(OVS / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVS - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, tick_idx;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic [15:0]      div_q;
    logic [SYNC_STAGES-1:0] sync_q, valid_q;
    logic             rx_sync, rx_prev_q, armed_q, sync_ok;
    logic             start_edge, tick, tick_en, maj;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
`endif

    // Synchronizer resets to idle-high. valid_q tracks when the chain holds real
    // line samples, so a line still low after reset cannot fake a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            valid_q   <= '0;
            rx_prev_q <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rs232_Rx};
            valid_q   <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            rx_prev_q <= rx_sync;
            armed_q   <= armed_q | (sync_ok & rx_sync);
        end
    end

    assign rx_sync    = sync_q[SYNC_STAGES-1];
    assign sync_ok    = valid_q[SYNC_STAGES-1];
    assign start_edge = (state_q == IDLE) && armed_q && rx_prev_q && !rx_sync;
    assign tick_en    = (state_q != IDLE);

    // Rate is frozen for the duration of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= DIV_9600;
        end else if (state_q == IDLE) begin
            div_q <= baud_div(baud_set);
        end
    end

    uart_baud_tick #(
        .W(16)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .div  (div_q),
        .en   (tick_en),
        .clr  (start_edge),
        .tick (tick)
    );

    // The start edge counts as tick 0 of the start bit, so this tick's index is one
    // past the last one seen.
    assign tick_idx = sample_cnt_q + CNT_W'(1);
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        data_d       = data_q;
        done_d       = 1'b0;
        ferr_d       = 1'b0;
        perr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        if (tick) begin
            sample_cnt_d = tick_idx;
            if (tick_idx == TICK_S0) samp_d[0] = rx_sync;
            if (tick_idx == TICK_S1) samp_d[1] = rx_sync;
        end
        case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                if (start_edge) state_d = START;
            end
            START: begin
                if (tick && tick_idx == TICK_DEC && maj != START_BIT) begin
                    state_d = IDLE;
                end else if (tick && tick_idx == TICK_LAST) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (tick && tick_idx == TICK_DEC) shift_d[bit_idx_q] = maj;
                if (tick && tick_idx == TICK_LAST) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && tick_idx == TICK_DEC) par_bad_d = (^shift_q) ^ maj;
                if (tick && tick_idx == TICK_LAST) state_d = STOP;
            end
`endif
            STOP: begin
                // Deciding at mid-stop re-arms in time for a back-to-back start bit.
                if (tick && tick_idx == TICK_DEC) begin
                    if (maj == STOP_BIT) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad_q;
`endif
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            samp_q       <= '1;
            data_q       <= '0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_bad_q <= 1'b0;
        else      par_bad_q <= par_bad_d;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_byte  = data_q;
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
    assign uart_state = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed self-checking bench for uart_byte_rx.
// A serial TX model drives rs232_Rx; a negedge monitor counts output pulses.
module tb_uart_byte_rx;

    localparam int SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Stop-bit tick 9 at 9.5625 bit times (16x, div 325) plus synchronizer + output flop.
    localparam int LAT_9600 = (16 * (9 + PAR_BITS) + 9) * 325 + SYNC_STAGES + 1;

    // clk cycles per bit: 16 * (divisor + 1)
    localparam int BIT_9600   = 5200;
    localparam int BIT_57600  = 864;
    localparam int BIT_115200 = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] baud_set;
    logic       rs232_Rx;
    logic [7:0] data_byte;
    logic       rx_done, frame_err, parity_err, uart_state;

    uart_byte_rx #(
        .OVS         (16),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_set   (baud_set),
        .rs232_Rx   (rs232_Rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .uart_state (uart_state)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    int          done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, excl_bad = 0;
    int unsigned last_done_cyc = 0, fall_cyc = 0;
    bit          state_seen = 1'b0;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) excl_bad++;
        if (uart_state) state_seen = 1'b1;
    end

    typedef struct {
        logic [2:0] baud;
        int         bit_clk;
        logic [7:0] data;
        logic       par;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rs232_Rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic stop_v,
                              input logic par_v);
        fall_cyc = cyc;
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(d[i], n);
`ifdef UART_RX_PARITY_EN
        send_bit(par_v, n);
`else
        if (par_v === 1'bx) rs232_Rx = 1'b1;
`endif
        send_bit(stop_v, n);
    endtask

    initial begin
        int d0, f0, p0, lat;

        // 0x00, 0xFF, 0x55 back-to-back at 115200 (parity bit = even parity of data)
        tbl[0] = '{3'b100, BIT_115200, 8'h00, 1'b0, 1, 0, 8'h00};
        tbl[1] = '{3'b100, BIT_115200, 8'hFF, 1'b0, 1, 0, 8'hFF};
        tbl[2] = '{3'b100, BIT_115200, 8'h55, 1'b0, 1, 0, 8'h55};

        rst      = 1'b0;
        rs232_Rx = 1'b1;
        baud_set = 3'b000;
        repeat (4) @(negedge clk);
        check("rst_data_byte", data_byte, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_uart_state", uart_state, 1'b0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // 0xA5 at 9600
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, BIT_9600, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("a5_data", data_byte, 8'hA5);
        check("a5_done_pulses", done_cnt - d0, 1);
        check("a5_frame_err", ferr_cnt - f0, 0);
        lat = int'(last_done_cyc - fall_cyc);
        n_cmp++;
        if (lat < LAT_9600 - 2 || lat > LAT_9600 + 2) begin
            n_fail++;
            $display("FAIL a5_latency: got %0d clk, expected %0d +/-2 clk", lat, LAT_9600);
        end

        // Table: back-to-back frames, no idle gap between them
        baud_set = 3'b100;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt; f0 = ferr_cnt;
            baud_set = tbl[i].baud;
            send_frame(tbl[i].data, tbl[i].bit_clk, 1'b1, tbl[i].par);
            check($sformatf("tbl%0d_done", i), done_cnt - d0, tbl[i].exp_done);
            check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
            check($sformatf("tbl%0d_data", i), data_byte, tbl[i].exp_data);
        end
        repeat (10) @(negedge clk);

        // 0.5 us glitch at 115200: false start
        d0 = done_cnt; f0 = ferr_cnt; state_seen = 1'b0;
        rs232_Rx = 1'b0;
        repeat (25) @(negedge clk);
        rs232_Rx = 1'b1;
        repeat (2 * BIT_115200) @(negedge clk);
        check("glitch_state_pulsed", state_seen, 1'b1);
        check("glitch_state_idle", uart_state, 1'b0);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_data_kept", data_byte, 8'h55);

        // 0x3C at 57600, stop bit low, line held low 3 more bit times
        baud_set = 3'b011;
        repeat (4) @(negedge clk);
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, BIT_57600, 1'b0, 1'b0);
        repeat (3 * BIT_57600) @(negedge clk);
        check("brk_state_high", uart_state, 1'b1);
        check("brk_one_ferr", ferr_cnt - f0, 1);
        check("brk_no_done", done_cnt - d0, 0);
        check("brk_data_kept", data_byte, 8'h55);
        rs232_Rx = 1'b1;
        repeat (10) @(negedge clk);
        check("brk_state_released", uart_state, 1'b0);
        check("brk_still_one_ferr", ferr_cnt - f0, 1);

        // Reset during bit 4 of 0x81, released while the line is still low
        baud_set = 3'b100;
        repeat (4) @(negedge clk);
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'h81, BIT_115200, 1'b1, 1'b0);
            begin
                repeat (5 * BIT_115200 + BIT_115200 / 2) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("mid_rst_state", uart_state, 1'b0);
                check("mid_rst_data", data_byte, 8'h00);
                rst = 1'b1;
            end
        join
        repeat (6 * BIT_115200) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_ferr", ferr_cnt - f0, 0);
        d0 = done_cnt;
        send_frame(8'h7E, BIT_115200, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("after_rst_done", done_cnt - d0, 1);
        check("after_rst_data", data_byte, 8'h7E);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even data parity: parity bit 1 is wrong, 0 is right
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h03, BIT_115200, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("par_bad_done", done_cnt - d0, 1);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_data", data_byte, 8'h03);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h03, BIT_115200, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("par_ok_done", done_cnt - d0, 1);
        check("par_ok_perr", perr_cnt - p0, 0);
`else
        p0 = perr_cnt;
        check("no_parity_err", p0, 0);
`endif
        check("pulses_exclusive", excl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
